// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: coin codes, coin values,
// FSM state encoding and default pricing/timeout parameters.
package vend_pkg;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;

  localparam logic [3:0] VAL_5  = 4'd5;
  localparam logic [3:0] VAL_10 = 4'd10;

  localparam int DEFAULT_PRICE   = 15;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  // Credit value of a coin code; invalid codes are worth nothing.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] val;
    case (code)
      COIN_5:  val = VAL_5;
      COIN_10: val = VAL_10;
      default: val = 4'd0;
    endcase
    return val;
  endfunction

  // True for coin codes the machine accepts.
  function automatic logic coin_code_ok(input logic [1:0] code);
    return (code == COIN_5) || (code == COIN_10);
  endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// Dispenser-ack watchdog: counts enabled cycles since the last clear and
// flags the cycle that completes TIMEOUT consecutive enabled cycles.
module vend_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count equals the number of enabled cycles already completed, so the
  // TIMEOUT-th enabled cycle sees TIMEOUT-1 here.
  assign expire = enable && (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear wins, otherwise advance while enabled and not expiring.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: collects 5/10 unit coins, requests a dispense once the
// price is reached, returns change or a refund, and flags dispenser timeouts.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE    = DEFAULT_PRICE,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT,
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                change_req,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                busy,
  output logic                fault
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic                change_req_q, change_req_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_sum;
  logic                tmo_clear;
  logic                tmo_enable;
  logic                tmo_expire;

  assign coin_ok    = coin_valid && coin_code_ok(coin_val);
  assign credit_sum = credit_q + CREDIT_W'(coin_value(coin_val));
  assign tmo_enable = (state_q == S_DISPENSE) && !disp_ack;

  vend_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = 1'b0;
    change_req_d  = 1'b0;
    change_amt_d  = '0;
    coin_reject_d = 1'b0;
    fault_d       = fault_q;

    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = credit_sum;
          if (credit_sum >= PRICE_C) begin
            state_d    = S_DISPENSE;
            disp_req_d = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (coin_ok) begin
          credit_d = credit_sum;
          if (credit_sum >= PRICE_C) begin
            state_d    = S_DISPENSE;
            disp_req_d = 1'b1;
          end else if (cancel) begin
            state_d      = S_RETURN;
            change_req_d = 1'b1;
            change_amt_d = credit_sum;
          end
        end else if (cancel) begin
          state_d      = S_RETURN;
          change_req_d = 1'b1;
          change_amt_d = credit_q;
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_ok;
        if (disp_ack) begin
          if (credit_q > PRICE_C) begin
            state_d      = S_RETURN;
            change_req_d = 1'b1;
            change_amt_d = credit_q - PRICE_C;
          end else begin
            state_d  = S_IDLE;
            credit_d = '0;
          end
        end else if (tmo_expire) begin
          state_d      = S_RETURN;
          fault_d      = 1'b1;
          change_req_d = 1'b1;
          change_amt_d = credit_q;
        end else begin
          disp_req_d = 1'b1;
        end
      end

      S_RETURN: begin
        coin_reject_d = coin_ok;
        state_d       = S_IDLE;
        credit_d      = '0;
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    tmo_clear = (state_d == S_DISPENSE) && (state_q != S_DISPENSE);
  end

  // State, credit and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      change_req_q  <= 1'b0;
      change_amt_q  <= '0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      change_req_q  <= change_req_d;
      change_amt_q  <= change_amt_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign change_req  = change_req_q;
  assign change_amt  = change_amt_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed testbench for vend_sequencer with hand-computed expectations.
`timescale 1ns/1ps
module tb_vend_sequencer;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       cancel;
  logic       disp_ack;
  logic       disp_req;
  logic       change_req;
  logic [4:0] change_amt;
  logic       coin_reject;
  logic       busy;
  logic       fault;

  int vec_count;
  int miscompares;

  vend_sequencer #(
    .PRICE    (15),
    .TIMEOUT  (255),
    .CREDIT_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .disp_req    (disp_req),
    .change_req  (change_req),
    .change_amt  (change_amt),
    .coin_reject (coin_reject),
    .busy        (busy),
    .fault       (fault)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one coin strobe for exactly one cycle.
  task automatic drive_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_val   = code;
    tick();
    coin_valid = 1'b0;
    coin_val   = 2'b00;
  endtask

  // Present one dispenser ack pulse.
  task automatic drive_ack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  // Reset clears every output and holds them while asserted.
  task automatic test_reset();
    #3;
    vec_count++; if ({disp_req, change_req, change_amt, coin_reject, busy, fault} !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_outputs: got %b expected %b", {disp_req, change_req, change_amt, coin_reject, busy, fault}, 10'd0); end
    coin_valid = 1'b1; coin_val = 2'b01;
    tick();
    coin_valid = 1'b0;
    vec_count++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hold_busy: got %b expected %b", busy, 1'b0); end
    rst = 1'b1;
    tick();
    vec_count++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_busy: got %b expected %b", busy, 1'b0); end
  endtask

  // Cancel and invalid coin codes in IDLE have no effect.
  task automatic test_idle_ignores();
    cancel = 1'b1; tick(); cancel = 1'b0;
    vec_count++; if ({busy, change_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL idle_cancel: got %b expected %b", {busy, change_req}, 2'b00); end
    drive_coin(2'b10);
    vec_count++; if ({busy, coin_reject} !== 2'b00) begin miscompares++; $display("[TB] FAIL idle_invalid_coin: got %b expected %b", {busy, coin_reject}, 2'b00); end
  endtask

  // Three 5-unit coins reach the price exactly; no change afterwards.
  task automatic test_exact_price();
    drive_coin(2'b00);
    vec_count++; if ({busy, disp_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL exact_after_c1: got %b expected %b", {busy, disp_req}, 2'b10); end
    drive_coin(2'b00);
    vec_count++; if (disp_req !== 1'b0) begin miscompares++; $display("[TB] FAIL exact_after_c2: got %b expected %b", disp_req, 1'b0); end
    drive_coin(2'b00);
    vec_count++; if (disp_req !== 1'b1) begin miscompares++; $display("[TB] FAIL exact_disp_req: got %b expected %b", disp_req, 1'b1); end
    tick(); tick();
    vec_count++; if (disp_req !== 1'b1) begin miscompares++; $display("[TB] FAIL exact_disp_hold: got %b expected %b", disp_req, 1'b1); end
    drive_ack();
    vec_count++; if ({disp_req, change_req, busy} !== 3'b000) begin miscompares++; $display("[TB] FAIL exact_after_ack: got %b expected %b", {disp_req, change_req, busy}, 3'b000); end
    tick();
    vec_count++; if (change_req !== 1'b0) begin miscompares++; $display("[TB] FAIL exact_no_change: got %b expected %b", change_req, 1'b0); end
  endtask

  // Two 10-unit coins overpay by 5; change follows the ack.
  task automatic test_change();
    drive_coin(2'b01);
    drive_coin(2'b01);
    vec_count++; if (disp_req !== 1'b1) begin miscompares++; $display("[TB] FAIL change_disp_req: got %b expected %b", disp_req, 1'b1); end
    drive_ack();
    vec_count++; if ({disp_req, change_req, busy} !== 3'b011) begin miscompares++; $display("[TB] FAIL change_pulse: got %b expected %b", {disp_req, change_req, busy}, 3'b011); end
    vec_count++; if (change_amt !== 5'd5) begin miscompares++; $display("[TB] FAIL change_amt: got %0d expected %0d", change_amt, 5); end
    tick();
    vec_count++; if ({change_req, change_amt, busy} !== 7'd0) begin miscompares++; $display("[TB] FAIL change_done: got %b expected %b", {change_req, change_amt, busy}, 7'd0); end
  endtask

  // Cancel after one 10-unit coin refunds it; also coin+cancel combinations.
  task automatic test_cancel();
    drive_coin(2'b01);
    cancel = 1'b1; tick(); cancel = 1'b0;
    vec_count++; if ({change_req, disp_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL cancel_pulse: got %b expected %b", {change_req, disp_req}, 2'b10); end
    vec_count++; if (change_amt !== 5'd10) begin miscompares++; $display("[TB] FAIL cancel_amt: got %0d expected %0d", change_amt, 10); end
    tick();
    vec_count++; if ({change_req, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL cancel_done: got %b expected %b", {change_req, busy}, 2'b00); end
    // 5 then 5+cancel: 10 is below price, so everything is refunded.
    drive_coin(2'b00);
    cancel = 1'b1; drive_coin(2'b00); cancel = 1'b0;
    vec_count++; if ({change_req, disp_req} !== 2'b10 || change_amt !== 5'd10) begin miscompares++; $display("[TB] FAIL cancel_coin_refund: got req=%b disp=%b amt=%0d expected req=1 disp=0 amt=10", change_req, disp_req, change_amt); end
    tick();
    // 10 then 5+cancel: reaches the price, so dispense wins.
    drive_coin(2'b01);
    cancel = 1'b1; drive_coin(2'b00); cancel = 1'b0;
    vec_count++; if ({change_req, disp_req} !== 2'b01) begin miscompares++; $display("[TB] FAIL cancel_coin_dispense: got %b expected %b", {change_req, disp_req}, 2'b01); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    vec_count++; if ({change_req, disp_req} !== 2'b01) begin miscompares++; $display("[TB] FAIL dispense_ignores_cancel: got %b expected %b", {change_req, disp_req}, 2'b01); end
    drive_ack();
    vec_count++; if ({change_req, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL cancel_coin_ack: got %b expected %b", {change_req, busy}, 2'b00); end
  endtask

  // No ack for 255 DISPENSE cycles: refund in full and latch fault.
  task automatic test_timeout();
    drive_coin(2'b01);
    drive_coin(2'b00);
    vec_count++; if ({disp_req, fault} !== 2'b10) begin miscompares++; $display("[TB] FAIL tmo_start: got %b expected %b", {disp_req, fault}, 2'b10); end
    repeat (254) tick();
    vec_count++; if ({disp_req, change_req, fault} !== 3'b100) begin miscompares++; $display("[TB] FAIL tmo_last_cycle: got %b expected %b", {disp_req, change_req, fault}, 3'b100); end
    tick();
    vec_count++; if ({disp_req, change_req, fault} !== 3'b011) begin miscompares++; $display("[TB] FAIL tmo_expire: got %b expected %b", {disp_req, change_req, fault}, 3'b011); end
    vec_count++; if (change_amt !== 5'd15) begin miscompares++; $display("[TB] FAIL tmo_amt: got %0d expected %0d", change_amt, 15); end
    tick();
    vec_count++; if ({change_req, busy, fault} !== 3'b001) begin miscompares++; $display("[TB] FAIL tmo_after: got %b expected %b", {change_req, busy, fault}, 3'b001); end
  endtask

  // A coin during DISPENSE is rejected and does not change the credit.
  task automatic test_coin_reject();
    drive_coin(2'b01);
    drive_coin(2'b01);
    drive_coin(2'b00);
    vec_count++; if ({coin_reject, disp_req} !== 2'b11) begin miscompares++; $display("[TB] FAIL reject_pulse: got %b expected %b", {coin_reject, disp_req}, 2'b11); end
    tick();
    vec_count++; if (coin_reject !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_clear: got %b expected %b", coin_reject, 1'b0); end
    drive_ack();
    vec_count++; if (change_req !== 1'b1 || change_amt !== 5'd5) begin miscompares++; $display("[TB] FAIL reject_change: got req=%b amt=%0d expected req=1 amt=5", change_req, change_amt); end
    drive_coin(2'b01);
    vec_count++; if ({coin_reject, busy, fault} !== 3'b101) begin miscompares++; $display("[TB] FAIL return_reject: got %b expected %b", {coin_reject, busy, fault}, 3'b101); end
    tick();
  endtask

  // Reset mid-DISPENSE clears everything at once; a fresh 5+10 vend works.
  task automatic test_reset_mid_dispense();
    drive_coin(2'b01);
    drive_coin(2'b01);
    #2 rst = 1'b0;
    #1;
    vec_count++; if ({disp_req, change_req, change_amt, coin_reject, busy, fault} !== 10'd0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %b expected %b", {disp_req, change_req, change_amt, coin_reject, busy, fault}, 10'd0); end
    tick();
    vec_count++; if (change_req !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_change: got %b expected %b", change_req, 1'b0); end
    rst = 1'b1;
    tick();
    drive_coin(2'b00);
    vec_count++; if ({busy, disp_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL fresh_after_c1: got %b expected %b", {busy, disp_req}, 2'b10); end
    drive_coin(2'b01);
    vec_count++; if (disp_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fresh_disp_req: got %b expected %b", disp_req, 1'b1); end
    drive_ack();
    vec_count++; if ({disp_req, change_req, busy, fault} !== 4'b0000) begin miscompares++; $display("[TB] FAIL fresh_done: got %b expected %b", {disp_req, change_req, busy, fault}, 4'b0000); end
  endtask

  // Run every scenario in sequence and report.
  initial begin
    clk         = 1'b0;
    rst         = 1'b0;
    coin_valid  = 1'b0;
    coin_val    = 2'b00;
    cancel      = 1'b0;
    disp_ack    = 1'b0;
    vec_count   = 0;
    miscompares = 0;

    test_reset();
    test_idle_ignores();
    test_exact_price();
    test_change();
    test_cancel();
    test_timeout();
    test_coin_reject();
    test_reset_mid_dispense();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
